// File: rtl/rf_arb_pkg.sv
// Shared types for the register-file write-port arbiter: register address width,
// arbiter FSM states and write-port ownership encoding.
package rf_arb_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_WB,
        OWN_LLU
    } owner_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard for long-latency results: one busy bit per register,
// set on LLU issue, cleared on LLU commit, looked up by three decode ports.
module rf_scoreboard
    import rf_arb_pkg::*;
#(
    parameter int NREG = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  i_set,
    input  logic [REG_ADDR_W-1:0] i_setRd,
    input  logic                  i_clr,
    input  logic [REG_ADDR_W-1:0] i_clrRd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    input  logic [REG_ADDR_W-1:0] i_rd,
    output logic                  o_hazard
);

    logic [NREG-1:0] r_busy;
    logic [NREG-1:0] w_busyNext;

    // Set is applied after clear so a same-cycle commit and re-issue keeps the bit.
    always_comb begin
        w_busyNext = r_busy;
        if (i_clr) begin
            w_busyNext[i_clrRd] = 1'b0;
        end
        if (i_set) begin
            w_busyNext[i_setRd] = 1'b1;
        end
        w_busyNext[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign o_hazard = r_busy[i_rs1] | r_busy[i_rs2] | r_busy[i_rd];

    // Re-issuing to a busy register is only legal when it commits in the same cycle.
    assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(i_set && (i_setRd != '0) && r_busy[i_setRd] && !(i_clr && (i_clrRd == i_setRd))));

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter between the WB stage and a long-latency unit.
// Optional starvation guard (WAIT/HOLD FSM, wb_hold_o) enabled by RF_ARB_STARVE_EN.
module rf_wb_arbiter
    import rf_arb_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int NREG       = 32,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  wb_wren_i,
    input  logic [REG_ADDR_W-1:0] wb_rd_i,
    input  logic [XLEN-1:0]       wb_data_i,
    output logic                  wb_hold_o,
    input  logic                  llu_issue_i,
    input  logic [REG_ADDR_W-1:0] llu_issue_rd_i,
    input  logic                  llu_valid_i,
    input  logic [REG_ADDR_W-1:0] llu_rd_i,
    input  logic [XLEN-1:0]       llu_data_i,
    output logic                  llu_ready_o,
    input  logic [REG_ADDR_W-1:0] dec_rs1_i,
    input  logic [REG_ADDR_W-1:0] dec_rs2_i,
    input  logic [REG_ADDR_W-1:0] dec_rd_i,
    output logic                  stall_o,
    output logic                  rf_wren_o,
    output logic [REG_ADDR_W-1:0] rf_addr_o,
    output logic [XLEN-1:0]       rf_data_o
);

    if (STARVE_MAX < 1) begin : gStarveMaxCheck
        $error("STARVE_MAX must be at least 1");
    end

    owner_t w_owner;
    logic   w_wbReq;
    logic   w_commit;
    logic   w_hazard;

    assign w_wbReq = wb_wren_i && (wb_rd_i != '0);

    // WB has priority; a WB write to x0 leaves the slot free for the LLU.
    always_comb begin
        w_owner = OWN_NONE;
        if (!rst_n_i) begin
            w_owner = OWN_NONE;
        end else if (w_wbReq) begin
            w_owner = OWN_WB;
        end else if (llu_valid_i) begin
            w_owner = OWN_LLU;
        end
    end

    always_comb begin
        rf_wren_o   = 1'b0;
        rf_addr_o   = '0;
        rf_data_o   = '0;
        llu_ready_o = 1'b0;
        case (w_owner)
            OWN_WB: begin
                rf_wren_o = 1'b1;
                rf_addr_o = wb_rd_i;
                rf_data_o = wb_data_i;
            end
            OWN_LLU: begin
                rf_wren_o   = (llu_rd_i != '0);
                rf_addr_o   = llu_rd_i;
                rf_data_o   = llu_data_i;
                llu_ready_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign w_commit = llu_valid_i && llu_ready_o;

    rf_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .i_set    (llu_issue_i),
        .i_setRd  (llu_issue_rd_i),
        .i_clr    (w_commit),
        .i_clrRd  (llu_rd_i),
        .i_rs1    (dec_rs1_i),
        .i_rs2    (dec_rs2_i),
        .i_rd     (dec_rd_i),
        .o_hazard (w_hazard)
    );

    assign stall_o = rst_n_i && w_hazard;

`ifdef RF_ARB_STARVE_EN
    localparam int CNT_W = $clog2(STARVE_MAX) + 1;

    arbState_t        r_state;
    arbState_t        w_nextState;
    logic [CNT_W-1:0] r_starveCnt;
    logic             r_wbHold;
    logic             w_blocked;

    assign w_blocked = llu_valid_i && !llu_ready_o;

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_blocked) begin
                    w_nextState = WAIT;
                end
            end
            WAIT: begin
                if (!w_blocked) begin
                    w_nextState = IDLE;
                end else if (r_starveCnt == CNT_W'(STARVE_MAX - 1)) begin
                    w_nextState = HOLD;
                end
            end
            HOLD: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // The hold flag is asserted during HOLD so the pipeline leaves the following slot empty.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state     <= IDLE;
            r_starveCnt <= '0;
            r_wbHold    <= 1'b0;
        end else begin
            r_state  <= w_nextState;
            r_wbHold <= (w_nextState == HOLD);
            if ((r_state == WAIT) && (w_nextState == WAIT)) begin
                if (r_starveCnt != '1) begin
                    r_starveCnt <= r_starveCnt + 1'b1;
                end
            end else begin
                r_starveCnt <= '0;
            end
        end
    end

    assign wb_hold_o = r_wbHold;

    assert property (@(posedge clk_i) disable iff (!rst_n_i) wb_hold_o |=> !w_wbReq);
`else
    assign wb_hold_o = 1'b0;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed self-checking bench for rf_wb_arbiter; the starvation section follows
// whichever RF_ARB_STARVE_EN build is compiled.
module tb_rf_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        wb_wren_i;
    logic [4:0]  wb_rd_i;
    logic [31:0] wb_data_i;
    logic        wb_hold_o;
    logic        llu_issue_i;
    logic [4:0]  llu_issue_rd_i;
    logic        llu_valid_i;
    logic [4:0]  llu_rd_i;
    logic [31:0] llu_data_i;
    logic        llu_ready_o;
    logic [4:0]  dec_rs1_i;
    logic [4:0]  dec_rs2_i;
    logic [4:0]  dec_rd_i;
    logic        stall_o;
    logic        rf_wren_o;
    logic [4:0]  rf_addr_o;
    logic [31:0] rf_data_o;

    int errors = 0;
    int checks = 0;

    rf_wb_arbiter #(
        .XLEN       (32),
        .NREG       (32),
        .STARVE_MAX (4)
    ) dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .wb_wren_i      (wb_wren_i),
        .wb_rd_i        (wb_rd_i),
        .wb_data_i      (wb_data_i),
        .wb_hold_o      (wb_hold_o),
        .llu_issue_i    (llu_issue_i),
        .llu_issue_rd_i (llu_issue_rd_i),
        .llu_valid_i    (llu_valid_i),
        .llu_rd_i       (llu_rd_i),
        .llu_data_i     (llu_data_i),
        .llu_ready_o    (llu_ready_o),
        .dec_rs1_i      (dec_rs1_i),
        .dec_rs2_i      (dec_rs2_i),
        .dec_rd_i       (dec_rd_i),
        .stall_o        (stall_o),
        .rf_wren_o      (rf_wren_o),
        .rf_addr_o      (rf_addr_o),
        .rf_data_o      (rf_data_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic nextCycle();
        @(posedge clk_i);
        #1;
    endtask

    task automatic applyStimulus(input logic wbWren, input logic [4:0] wbRd, input logic [31:0] wbData,
                                 input logic lluValid, input logic [4:0] lluRd, input logic [31:0] lluData);
        wb_wren_i   = wbWren;
        wb_rd_i     = wbRd;
        wb_data_i   = wbData;
        llu_valid_i = lluValid;
        llu_rd_i    = lluRd;
        llu_data_i  = lluData;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n_i        = 1'b0;
        llu_issue_i    = 1'b0;
        llu_issue_rd_i = '0;
        dec_rs1_i      = 5'd7;
        dec_rs2_i      = '0;
        dec_rd_i       = '0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h77);

        // Reset held with a valid LLU result pending.
        #2;
        checkOutput("rst_wren", 32'(rf_wren_o), 32'd0);
        checkOutput("rst_ready", 32'(llu_ready_o), 32'd0);
        checkOutput("rst_stall", 32'(stall_o), 32'd0);
        checkOutput("rst_hold", 32'(wb_hold_o), 32'd0);
        repeat (2) nextCycle();
        checkOutput("rst_wren_edges", 32'(rf_wren_o), 32'd0);
        checkOutput("rst_ready_edges", 32'(llu_ready_o), 32'd0);

        // Release: scoreboard empty, LLU takes the first free slot.
        rst_n_i = 1'b1;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h99);
        dec_rs1_i = 5'd9;
        #1;
        checkOutput("post_rst_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("post_rst_wren", 32'(rf_wren_o), 32'd1);
        checkOutput("post_rst_addr", 32'(rf_addr_o), 32'd9);
        checkOutput("post_rst_data", rf_data_o, 32'h99);
        checkOutput("post_rst_stall", 32'(stall_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        dec_rs1_i = '0;

        // WB x5 wins over LLU x7, LLU commits the following free cycle.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 1'b1, 5'd7, 32'h1234);
        #1;
        checkOutput("wb_win_addr", 32'(rf_addr_o), 32'd5);
        checkOutput("wb_win_data", rf_data_o, 32'hDEAD_BEEF);
        checkOutput("wb_win_wren", 32'(rf_wren_o), 32'd1);
        checkOutput("wb_win_ready", 32'(llu_ready_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 32'h1234);
        #1;
        checkOutput("llu_next_addr", 32'(rf_addr_o), 32'd7);
        checkOutput("llu_next_data", rf_data_o, 32'h1234);
        checkOutput("llu_next_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("llu_next_hold", 32'(wb_hold_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Issue to x3; RAW on rs1/rs2 and WAW on rd until the cycle after commit.
        llu_issue_i    = 1'b1;
        llu_issue_rd_i = 5'd3;
        dec_rs1_i      = 5'd3;
        #1;
        checkOutput("x3_issue_cycle_stall", 32'(stall_o), 32'd0);
        nextCycle();
        llu_issue_i = 1'b0;
        #1;
        checkOutput("x3_rs1_stall", 32'(stall_o), 32'd1);
        dec_rs1_i = 5'd0;
        dec_rs2_i = 5'd3;
        #1;
        checkOutput("x3_rs2_stall", 32'(stall_o), 32'd1);
        dec_rs2_i = 5'd0;
        dec_rd_i  = 5'd3;
        #1;
        checkOutput("x3_waw_stall", 32'(stall_o), 32'd1);
        dec_rd_i = 5'd2;
        #1;
        checkOutput("x3_other_stall", 32'(stall_o), 32'd0);
        nextCycle();
        dec_rs1_i = 5'd3;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 32'h33);
        #1;
        checkOutput("x3_commit_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("x3_commit_nobypass", 32'(stall_o), 32'd1);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("x3_after_commit_stall", 32'(stall_o), 32'd0);
        dec_rs1_i = '0;
        dec_rd_i  = '0;

        // Same-cycle commit and re-issue of x4: set wins.
        llu_issue_i    = 1'b1;
        llu_issue_rd_i = 5'd4;
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h44);
        dec_rd_i = 5'd4;
        #1;
        checkOutput("x4_commit_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("x4_commit_stall", 32'(stall_o), 32'd1);
        nextCycle();
        llu_issue_i = 1'b0;
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("x4_still_busy", 32'(stall_o), 32'd1);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd4, 32'h45);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        #1;
        checkOutput("x4_cleared", 32'(stall_o), 32'd0);
        dec_rd_i = '0;

        // x0 is never busy; LLU result to x0 is accepted without a write.
        llu_issue_i    = 1'b1;
        llu_issue_rd_i = 5'd0;
        nextCycle();
        llu_issue_i = 1'b0;
        #1;
        checkOutput("x0_never_busy", 32'(stall_o), 32'd0);
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h5);
        #1;
        checkOutput("llu_x0_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("llu_x0_wren", 32'(rf_wren_o), 32'd0);
        nextCycle();
        applyStimulus(1'b1, 5'd0, 32'hAA, 1'b1, 5'd8, 32'h88);
        #1;
        checkOutput("wb_x0_free_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("wb_x0_free_wren", 32'(rf_wren_o), 32'd1);
        checkOutput("wb_x0_free_addr", 32'(rf_addr_o), 32'd8);
        checkOutput("wb_x0_free_data", rf_data_o, 32'h88);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);

        // Mid-operation asynchronous reset clears pending registers.
        llu_issue_i    = 1'b1;
        llu_issue_rd_i = 5'd11;
        nextCycle();
        llu_issue_i = 1'b0;
        dec_rs1_i   = 5'd11;
        #1;
        checkOutput("x11_busy", 32'(stall_o), 32'd1);
        #1;
        rst_n_i = 1'b0;
        #1;
        checkOutput("x11_in_reset", 32'(stall_o), 32'd0);
        #1;
        rst_n_i = 1'b1;
        #1;
        checkOutput("x11_after_reset", 32'(stall_o), 32'd0);
        nextCycle();
        dec_rs1_i = '0;

        // WB writing every cycle while the LLU waits for x10.
        applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'd10, 32'hA0);
`ifdef RF_ARB_STARVE_EN
        for (int c = 0; c < 5; c++) begin
            #1;
            checkOutput($sformatf("starve_hold_c%0d", c), 32'(wb_hold_o), 32'd0);
            checkOutput($sformatf("starve_ready_c%0d", c), 32'(llu_ready_o), 32'd0);
            nextCycle();
        end
        #1;
        checkOutput("starve_hold_pulse", 32'(wb_hold_o), 32'd1);
        checkOutput("starve_hold_ready", 32'(llu_ready_o), 32'd0);
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
        #1;
        checkOutput("starve_commit_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("starve_commit_addr", 32'(rf_addr_o), 32'd10);
        checkOutput("starve_hold_drop", 32'(wb_hold_o), 32'd0);
`else
        for (int c = 0; c < 8; c++) begin
            #1;
            checkOutput($sformatf("nostarve_hold_c%0d", c), 32'(wb_hold_o), 32'd0);
            checkOutput($sformatf("nostarve_ready_c%0d", c), 32'(llu_ready_o), 32'd0);
            nextCycle();
        end
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd10, 32'hA0);
        #1;
        checkOutput("nostarve_commit_ready", 32'(llu_ready_o), 32'd1);
        checkOutput("nostarve_commit_addr", 32'(rf_addr_o), 32'd10);
`endif
        nextCycle();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        nextCycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
